processor_memory_copier: RTL and testbench
==========================================

# processor_memory_copier

Avalon-MM master block-copy/fill engine driving the single-port 12288 × 32-bit on-chip processor memory. Copies a run of words from one word address to another, or fills a run with a constant pattern, without processor involvement. Sits between a control register block (start/params/status) and the memory's slave port, using its fixed one-cycle read latency and no waitrequest.

## Interface
Parameters:
- DEPTH, 12288, memory depth in words
- AW, 14, word address width
- DW, 32, data width
- LW, 15, length/counter width (AW+1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  AW  copy source start word address
- dst_addr  in  AW  destination start word address
- length  in  LW  word count, 0..DEPTH
- pattern  in  DW  fill value
- abort  in  1  terminate current command
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  last command rejected (range)
- aborted  out  1  last command terminated by abort
- words_done  out  LW  completed writes of current/last command
- avm_address  out  AW  memory word address
- avm_byteenable  out  4  constant 4'hF
- avm_chipselect  out  1  memory access strobe
- avm_write  out  1  write qualifier
- avm_writedata  out  DW  write data
- avm_readdata  in  DW  memory read data, valid the cycle after the read address cycle

## Operation
- States: IDLE, RD, LAT, WR, FILL, DONE.
- IDLE: start=1 latches src, dst, length, mode, pattern; clears words_done, error, aborted. Range check in LW-bit arithmetic: fail if dst_addr+length > DEPTH, or (copy) src_addr+length > DEPTH → error=1, go DONE, no bus access. length=0 → DONE, error=0, no access. Otherwise copy → RD, fill → FILL.
- RD: chipselect=1, write=0, address=src+i → LAT.
- LAT: strobes low; capture avm_readdata into data register at end of cycle → WR.
- WR: chipselect=1, write=1, address=dst+i, writedata=data register; words_done+1; last word → DONE, else RD with i+1.
- FILL: chipselect=1, write=1, address=dst+i, writedata=pattern each cycle; words_done+1; last word → DONE.
- DONE: done=1 for one cycle → IDLE.
- Copy is strictly ascending address order; overlapping ranges with dst inside (src, src+length) propagate already-written words (defined, not corrected).
- abort=1 in RD/LAT/FILL/WR → DONE next cycle, aborted=1. In WR/FILL the access presented that cycle still completes and is counted; a word read but not yet written is discarded. abort ignored in IDLE/DONE.
- start ignored outside IDLE (including the DONE cycle); latched parameters immune to input changes while busy.
- busy=1 in RD, LAT, WR, FILL only.
- error/aborted/words_done hold until next accepted start.

## Timing
- Reset: state IDLE; busy, done, error, aborted, words_done, chipselect, write, address, writedata all 0; byteenable 4'hF. Reset mid-command: bus strobes low in the cycle after the reset edge; no further accesses.
- start sampled in cycle 0. Copy of N words: busy cycles 1..3N, reads in cycles 3k+1, writes in 3k+3 (k=0..N-1), done in cycle 3N+1.
- Fill of N words: writes in cycles 1..N, done in N+1.
- length=0 or range error: done (with error as applicable) in cycle 1, busy never asserted.
- Abort sampled in cycle c: done in c+1.
- Next start accepted in cycle after done at earliest.
- Bus outputs are decoded from registered state/counters only; no combinational path from avm_readdata to any output.

## Test plan
- Preload mem[100..103]=A0..A3, copy src=100 dst=2000 len=4 -> mem[2000..2003]=A0..A3, done at cycle 13, words_done=4, error=0.
- Fill dst=12280 len=8 pattern=32'hDEADBEEF -> words 12280..12287 written, done at cycle 9; then len=9 same dst -> error=1, done at cycle 1, zero bus writes.
- Copy len=0 -> done at cycle 1, error=0, chipselect never high.
- Copy len=10, abort sampled in 2nd WR cycle (cycle 6) -> that write completes, words_done=2, aborted=1, done at cycle 7, dst+2.. untouched.
- Overlap copy src=10 dst=11 len=3 with mem[10]=X -> mem[11..13]=X.
- reset_n low during fill word 5 of 20 -> next cycle all outputs zero, state IDLE, no further writes; start afterwards accepted normally; start pulses while busy ignored.

Source files
------------

// File: rtl/processor_memory_copier.sv
// Block-copy / fill engine acting as an Avalon-MM master on the single-port on-chip memory.
// Copies use a read / latency / write cadence of three cycles per word; fills write one word per cycle.
module processor_memory_copier #(
    parameter int DEPTH = 12288,
    parameter int AW    = 14,
    parameter int DW    = 32,
    parameter int LW    = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
    input  logic [DW-1:0] pattern,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          aborted,
    output logic [LW-1:0] words_done,
    output logic [AW-1:0] avm_address,
    output logic [3:0]    avm_byteenable,
    output logic          avm_chipselect,
    output logic          avm_write,
    output logic [DW-1:0] avm_writedata,
    input  logic [DW-1:0] avm_readdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [LW:0] DEPTH_W = (LW+1)'(DEPTH);

    logic [2:0]    r_state;
    logic          r_mode;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_len;
    logic [DW-1:0] r_pattern;
    logic [DW-1:0] r_data;
    logic [LW-1:0] r_words_done;
    logic          r_error;
    logic          r_aborted;

    logic [LW:0]   w_dst_end;
    logic [LW:0]   w_src_end;
    logic          w_range_err;
    logic          w_last;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_addr;

    // One bit wider than the length so an out-of-range request can never wrap into a legal one.
    assign w_dst_end   = (LW+1)'(dst_addr) + (LW+1)'(length);
    assign w_src_end   = (LW+1)'(src_addr) + (LW+1)'(length);
    assign w_range_err = (w_dst_end > DEPTH_W) || (!mode && (w_src_end > DEPTH_W));

    // The completed-write count doubles as the word index of the access in flight.
    assign w_last    = ((r_words_done + LW'(1)) == r_len);
    assign w_rd_addr = r_src + r_words_done[AW-1:0];
    assign w_wr_addr = r_dst + r_words_done[AW-1:0];

    assign busy           = (r_state == S_RD) || (r_state == S_LAT) ||
                            (r_state == S_WR) || (r_state == S_FILL);
    assign done           = (r_state == S_DONE);
    assign error          = r_error;
    assign aborted        = r_aborted;
    assign words_done     = r_words_done;
    assign avm_byteenable = 4'hF;

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        case (r_state)
            S_RD: begin
                avm_chipselect = 1'b1;
                avm_address    = w_rd_addr;
            end
            S_WR: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = w_wr_addr;
                avm_writedata  = r_data;
            end
            S_FILL: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = w_wr_addr;
                avm_writedata  = r_pattern;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_pattern    <= '0;
            r_data       <= '0;
            r_words_done <= '0;
            r_error      <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode       <= mode;
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_len        <= length;
                        r_pattern    <= pattern;
                        r_words_done <= '0;
                        r_error      <= w_range_err;
                        r_aborted    <= 1'b0;
                        if (w_range_err || (length == '0))
                            r_state <= S_DONE;
                        else
                            r_state <= mode ? S_FILL : S_RD;
                    end
                end
                S_RD: begin
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_LAT;
                    end
                end
                S_LAT: begin
                    r_data <= avm_readdata;
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_WR;
                    end
                end
                S_WR, S_FILL: begin
                    // The write presented this cycle always lands, so it is counted even on abort.
                    r_words_done <= r_words_done + LW'(1);
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else if (r_state == S_WR) begin
                        r_state <= S_RD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_memory_copier.sv
// Bench for processor_memory_copier: behavioural memory, array reference model, directed and random commands.
module tb_processor_memory_copier;

    localparam int DEPTH = 12288;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, mode, abort;
    logic [13:0] src_addr, dst_addr;
    logic [14:0] length;
    logic [31:0] pattern;
    logic        busy, done, error, aborted;
    logic [14:0] words_done;
    logic [13:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect, avm_write;
    logic [31:0] avm_writedata, avm_readdata;

    processor_memory_copier dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .pattern(pattern),
        .abort(abort), .busy(busy), .done(done), .error(error), .aborted(aborted),
        .words_done(words_done), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    // Memory with one-cycle registered read, plus a preload/clear port for the bench.
    logic [31:0] mem [0:DEPTH-1];
    logic        pl_en, pl_clr, cnt_clr;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;
    int          cs_cnt, wr_cnt;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (avm_chipselect && avm_write && int'(avm_address) < DEPTH) begin
            mem[avm_address] <= avm_writedata;
        end
        if (avm_chipselect && !avm_write && int'(avm_address) < DEPTH)
            avm_readdata <= mem[avm_address];
    end

    always @(posedge clk) begin
        if (cnt_clr) begin
            cs_cnt <= 0;
            wr_cnt <= 0;
        end else if (avm_chipselect) begin
            cs_cnt <= cs_cnt + 1;
            if (avm_write) wr_cnt <= wr_cnt + 1;
        end
    end

    logic [31:0] ref_mem [0:DEPTH-1];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        @(negedge clk);
        pl_clr = 1'b1;
        @(negedge clk);
        pl_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = 14'(a);
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        int diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, 64'(diffs), 64'd0);
    endtask

    // One command: the model derives expected completion, counts and memory image from the rules directly.
    task automatic run_cmd(input string tag, input bit m, input int s, input int d, input int len,
                           input logic [31:0] pat, input int abort_cyc);
        int  exp_done, exp_words, exp_cs, done_cyc, bus_bad, k, ph, e_addr;
        bit  err, ab, e_cs, e_wr;
        err = (d + len > DEPTH) || (!m && (s + len > DEPTH));
        if (err || len == 0) exp_done = 1;
        else exp_done = m ? len + 1 : 3 * len + 1;
        ab = 1'b0;
        if (!err && len != 0 && abort_cyc > 0 && abort_cyc < exp_done) begin
            ab = 1'b1;
            exp_done = abort_cyc + 1;
        end
        if (err || len == 0) exp_words = 0;
        else if (ab) exp_words = m ? abort_cyc : abort_cyc / 3;
        else exp_words = len;
        exp_cs = m ? exp_words : 2 * exp_words;
        for (int i = 0; i < exp_words; i++)
            ref_mem[d + i] = m ? pat : ref_mem[s + i];

        @(negedge clk);
        mode = m; src_addr = 14'(s); dst_addr = 14'(d); length = 15'(len); pattern = pat;
        start = 1'b1; cnt_clr = 1'b1;
        done_cyc = -1;
        bus_bad  = 0;
        for (int c = 1; c <= 3 * len + 10; c++) begin
            @(negedge clk);
            cnt_clr  = 1'b0;
            src_addr = 14'($urandom); dst_addr = 14'($urandom);
            length   = 15'($urandom); pattern  = $urandom; mode = 1'($urandom);
            start    = (c == 1);
            abort    = (c == abort_cyc);
            if (done) begin
                done_cyc = c;
                if (busy !== 1'b0) bus_bad++;
                break;
            end
            if (m) begin
                e_cs = 1'b1; e_wr = 1'b1; e_addr = d + c - 1;
            end else begin
                k = (c - 1) / 3; ph = (c - 1) % 3;
                e_cs = (ph != 1); e_wr = (ph == 2); e_addr = (ph == 0) ? s + k : d + k;
            end
            if (busy !== 1'b1 || avm_chipselect !== e_cs || avm_write !== e_wr ||
                (e_cs && avm_address !== 14'(e_addr)))
                bus_bad++;
        end
        abort = 1'b0;
        // A fresh legal start during the completion cycle must be ignored.
        start = 1'b1; mode = 1'b1; dst_addr = '0; length = 15'd4;
        @(negedge clk);
        start = 1'b0;
        $display("cmd %s: mode=%0d src=%0d dst=%0d len=%0d abort_cyc=%0d done_cyc=%0d words=%0d err=%0d abt=%0d",
                 tag, m, s, d, len, abort_cyc, done_cyc, words_done, error, aborted);
        check({tag, " done cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, " bus timing"}, 64'(bus_bad), 64'd0);
        check({tag, " idle after done"}, {62'd0, busy, done}, 64'd0);
        check({tag, " words_done"}, 64'(words_done), 64'(exp_words));
        check({tag, " error"}, 64'(error), 64'(err));
        check({tag, " aborted"}, 64'(aborted), 64'(ab));
        check({tag, " write count"}, 64'(wr_cnt), 64'(exp_words));
        if (!ab) check({tag, " access count"}, 64'(cs_cnt), 64'(exp_cs));
        mem_compare({tag, " memory"});
    endtask

    initial begin
        logic [31:0] xval;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; pattern = '0;
        pl_en = 1'b0; pl_clr = 1'b0; cnt_clr = 1'b1; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        check("reset flags", {60'd0, busy, done, error, aborted}, 64'd0);
        check("reset words_done", 64'(words_done), 64'd0);
        check("reset bus", {48'd0, avm_chipselect, avm_write, avm_address}, 64'd0);
        check("reset writedata", 64'(avm_writedata), 64'd0);
        check("reset byteenable", 64'(avm_byteenable), 64'hF);
        reset_n = 1'b1;
        cnt_clr = 1'b0;
        clear_mem();

        for (int i = 0; i < 4; i++) poke(100 + i, $urandom);
        run_cmd("copy4", 1'b0, 100, 2000, 4, 32'h0, 0);

        run_cmd("fill8 tail", 1'b1, 0, 12280, 8, 32'hDEADBEEF, 0);
        run_cmd("fill9 range", 1'b1, 0, 12280, 9, 32'hDEADBEEF, 0);
        run_cmd("copy len0", 1'b0, 50, 60, 0, 32'h0, 0);
        run_cmd("copy src range", 1'b0, 12280, 0, 9, 32'h0, 0);

        for (int i = 0; i < 10; i++) poke(300 + i, $urandom);
        run_cmd("copy10 abort", 1'b0, 300, 4000, 10, 32'h0, 6);
        run_cmd("fill abort", 1'b1, 0, 5000, 7, 32'h12345678, 3);

        xval = $urandom;
        poke(10, xval);
        for (int i = 1; i < 4; i++) poke(10 + i, $urandom);
        run_cmd("overlap", 1'b0, 10, 11, 3, 32'h0, 0);
        check("overlap tail word", 64'(mem[13]), 64'(xval));

        // Reset asserted while the fifth fill word is on the bus.
        for (int i = 0; i < 5; i++) ref_mem[500 + i] = 32'hCAFEF00D;
        @(negedge clk);
        mode = 1'b1; dst_addr = 14'd500; length = 15'd20; pattern = 32'hCAFEF00D;
        start = 1'b1; cnt_clr = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            cnt_clr = 1'b0;
            start = (c == 3);
            length = 15'($urandom_range(1, 30));
            if (c == 5) begin
                check("rst-mid words before", 64'(words_done), 64'd4);
                reset_n = 1'b0;
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset mid-fill: busy=%0d cs=%0d wr=%0d addr=%0d words=%0d",
                 busy, avm_chipselect, avm_write, avm_address, words_done);
        check("rst-mid flags", {60'd0, busy, done, error, aborted}, 64'd0);
        check("rst-mid words_done", 64'(words_done), 64'd0);
        check("rst-mid bus", {48'd0, avm_chipselect, avm_write, avm_address}, 64'd0);
        check("rst-mid writedata", 64'(avm_writedata), 64'd0);
        repeat (4) @(negedge clk);
        check("rst-mid write count", 64'(wr_cnt), 64'd5);
        check("rst-mid access count", 64'(cs_cnt), 64'd5);
        mem_compare("rst-mid memory");

        for (int t = 0; t < 12; t++) begin
            bit m;
            int s, d, len, ac;
            m   = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            s   = $urandom_range(0, DEPTH - 1);
            d   = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 12, DEPTH - 1)
                                              : $urandom_range(0, DEPTH - 1);
            ac  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * len + 1) : 0;
            if (!m)
                for (int i = 0; i < len; i++)
                    if (s + i < DEPTH) poke(s + i, $urandom);
            run_cmd($sformatf("rand%0d", t), m, s, d, len, $urandom, ac);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
